// File: rtl/ds_temp_ctrl.sv
// DS18B20 measurement sequencer driving the 1-wire bit layer via its rdy handshake.
// Build option: define DS_CRC_EN to read all 9 scratchpad bytes and check the Dallas CRC8.
module ds_temp_ctrl #(
    parameter int         CNT_CONV = 18750000,
    parameter logic [7:0] CMD_SKIP = 8'hCC,
    parameter logic [7:0] CMD_CONV = 8'h44,
    parameter logic [7:0] CMD_READ = 8'hBE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        rst_en,
    output logic        wr_en,
    output logic        wdata,
    output logic        rd_en,
    input  logic        rdata,
    input  logic        rdata_vld,
    input  logic        rdy,
    output logic [15:0] temp,
    output logic        temp_vld,
    output logic        crc_err
);
    localparam int CNT_W = $clog2(CNT_CONV + 1);
`ifdef DS_CRC_EN
    localparam logic [6:0] RD_LAST = 7'd71;
`else
    localparam logic [6:0] RD_LAST = 7'd15;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_RST1, S_WR_SKIP1, S_WR_CONV, S_WAIT_CONV,
        S_RST2, S_WR_SKIP2, S_WR_READ, S_RD, S_RST3, S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_pend;
    logic              r_ign;
    logic [6:0]        r_bit;
    logic [CNT_W-1:0]  r_cnt;
    logic [6:0]        r_vld_cnt;
    logic [7:0]        r_byte;
    logic [7:0]        r_lsb;
    logic [7:0]        r_msb;
    logic [15:0]       r_temp;
    logic              r_temp_vld;
    logic              w_rst_st;
    logic              w_wr_st;
    logic              w_rd_st;
    logic              w_cmd_done;
    logic              w_issue;
    logic              w_last;
    logic              w_cnt_tc;
    logic              w_result_ok;
    logic [7:0]        w_cmd;
    logic [7:0]        w_byte_in;

    always_comb begin
        w_rst_st     = (r_state == S_RST1) || (r_state == S_RST2) || (r_state == S_RST3);
        w_wr_st      = (r_state == S_WR_SKIP1) || (r_state == S_WR_CONV) ||
                       (r_state == S_WR_SKIP2) || (r_state == S_WR_READ);
        w_rd_st      = (r_state == S_RD);
        w_cmd        = CMD_SKIP;
        if (r_state == S_WR_CONV) w_cmd = CMD_CONV;
        if (r_state == S_WR_READ) w_cmd = CMD_READ;
        // rdy is not trusted in the cycle right after a pulse (r_ign)
        w_cmd_done   = r_pend && !r_ign && rdy;
        w_issue      = (w_rst_st || w_wr_st || w_rd_st) && !r_pend && rdy && !rst_n;
        w_last       = 1'b1;
        if (w_wr_st) w_last = (r_bit == 7'd7);
        else if (w_rd_st) w_last = (r_bit == RD_LAST);
        w_cnt_tc     = (r_cnt == CNT_W'(CNT_CONV - 1));
        w_byte_in    = {rdata, r_byte[7:1]};
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_next = S_RST1;
            S_RST1:      if (w_cmd_done) w_state_next = S_WR_SKIP1;
            S_WR_SKIP1:  if (w_cmd_done && w_last) w_state_next = S_WR_CONV;
            S_WR_CONV:   if (w_cmd_done && w_last) w_state_next = S_WAIT_CONV;
            S_WAIT_CONV: if (w_cnt_tc) w_state_next = S_RST2;
            S_RST2:      if (w_cmd_done) w_state_next = S_WR_SKIP2;
            S_WR_SKIP2:  if (w_cmd_done && w_last) w_state_next = S_WR_READ;
            S_WR_READ:   if (w_cmd_done && w_last) w_state_next = S_RD;
`ifdef DS_CRC_EN
            S_RD:        if (w_cmd_done && w_last) w_state_next = S_DONE;
`else
            S_RD:        if (w_cmd_done && w_last) w_state_next = S_RST3;
`endif
            S_RST3:      if (w_cmd_done) w_state_next = S_DONE;
            S_DONE:      w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

`ifdef DS_CRC_EN
    logic [7:0] r_crc;
    logic       r_crc_err;
    logic       w_crc_fb;
    assign w_crc_fb    = r_crc[0] ^ rdata;
    assign w_result_ok = (r_crc == 8'h00);
    assign crc_err     = r_crc_err;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_crc     <= 8'h00;
            r_crc_err <= 1'b0;
        end else begin
            r_crc_err <= (w_state_next == S_DONE) && (r_state != S_DONE) && !w_result_ok;
            if (r_state == S_IDLE) r_crc <= 8'h00;
            else if (w_rd_st && rdata_vld)
                r_crc <= {1'b0, r_crc[7:1]} ^ (w_crc_fb ? 8'h8C : 8'h00);
        end
    end
`else
    assign w_result_ok = 1'b1;
    assign crc_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_pend     <= 1'b0;
            r_ign      <= 1'b0;
            r_bit      <= '0;
            r_cnt      <= '0;
            r_vld_cnt  <= '0;
            r_byte     <= '0;
            r_lsb      <= '0;
            r_msb      <= '0;
            r_temp     <= '0;
            r_temp_vld <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ign      <= w_issue;
            r_temp_vld <= 1'b0;
            if (w_issue) r_pend <= 1'b1;
            else if (w_cmd_done) r_pend <= 1'b0;
            if (w_state_next != r_state) r_bit <= '0;
            else if (w_cmd_done) r_bit <= r_bit + 7'd1;
            if (r_state == S_WAIT_CONV) r_cnt <= w_cnt_tc ? '0 : r_cnt + 1'b1;
            if (r_state == S_IDLE) begin
                r_vld_cnt <= '0;
            end else if (w_rd_st && rdata_vld) begin
                r_byte    <= w_byte_in;
                r_vld_cnt <= r_vld_cnt + 7'd1;
                if (r_vld_cnt[2:0] == 3'd7) begin
                    if (r_vld_cnt[6:3] == 4'd0) r_lsb <= w_byte_in;
                    if (r_vld_cnt[6:3] == 4'd1) r_msb <= w_byte_in;
                end
            end
            if ((w_state_next == S_DONE) && (r_state != S_DONE) && w_result_ok) begin
                r_temp     <= {r_msb, r_lsb};
                r_temp_vld <= 1'b1;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign rst_en   = w_issue && w_rst_st;
    assign wr_en    = w_issue && w_wr_st;
    assign rd_en    = w_issue && w_rd_st;
    assign wdata    = wr_en && w_cmd[r_bit[2:0]];
    assign temp     = r_temp;
    assign temp_vld = r_temp_vld;
endmodule

// File: tb/tb_ds_temp_ctrl.sv
// Scoreboard bench for ds_temp_ctrl with a bit-layer model (rdy low 6 cycles per command).
// Build with DS_CRC_EN defined to exercise the 9-byte CRC read path.
module tb_ds_temp_ctrl;
    localparam int CNT_CONV = 20;
`ifdef DS_CRC_EN
    localparam int RD_N = 72;
`else
    localparam int RD_N = 16;
`endif
    // pulse codes in the expected queue
    localparam logic [1:0] P_RST = 2'd0, P_W0 = 2'd1, P_W1 = 2'd2, P_RD = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, busy, rst_en, wr_en, wdata, rd_en;
    logic        rdata, rdata_vld, rdy, temp_vld, crc_err;
    logic [15:0] temp;

    ds_temp_ctrl #(.CNT_CONV(CNT_CONV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .rst_en(rst_en), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata), .rdata_vld(rdata_vld), .rdy(rdy),
        .temp(temp), .temp_vld(temp_vld), .crc_err(crc_err)
    );

    typedef struct packed {logic err; logic [15:0] t;} res_t;

    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, pidx = 0, t_conv = 0, n_pulse = 0, n_res = 0;
    logic [1:0]  exp_q[$];
    res_t        res_q[$];
    logic [7:0]  rd_bytes[9];
    int          rd_k = 0;
    logic        inject = 1'b0;
    logic [1:0]  code;
    res_t        r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // bit-layer model: rdy lags one cycle, then low 6 cycles; read strobe in last low cycle
    initial begin : model
        int  mcnt;
        logic seen, seen_rd, mrd;
        mcnt = 0; mrd = 1'b0;
        rdy = 1'b1; rdata_vld = 1'b0; rdata = 1'b0;
        forever begin
            @(negedge clk);
            seen    = rst_en | wr_en | rd_en;
            seen_rd = rd_en;
            @(posedge clk);
            #1;
            rdata_vld = 1'b0;
            if (rst_n) begin
                mcnt = 0; rdy = 1'b1;
            end else if (seen) begin
                mcnt = 7; mrd = seen_rd; rdy = 1'b1;
            end else if (mcnt > 0) begin
                mcnt--;
                rdy = (mcnt == 0);
                if (mcnt == 1 && mrd) begin
                    rdata_vld = 1'b1;
                    rdata     = rd_bytes[rd_k / 8][rd_k % 8];
                    rd_k++;
                end
            end else if (inject && pidx >= 1 && pidx <= 30) begin
                rdata_vld = 1'b1;
                rdata     = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (int'(rst_en) + int'(wr_en) + int'(rd_en) > 1) begin
            n_tests++; n_fail++;
            $display("FAIL one_hot: got rst=%0b wr=%0b rd=%0b, expected at most one", rst_en, wr_en, rd_en);
        end
        if (rst_en | wr_en | rd_en) begin
            code = rst_en ? P_RST : (wr_en ? (wdata ? P_W1 : P_W0) : P_RD);
            n_pulse++;
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_pulse: got code %0d, expected none", code);
            end else begin
                chk($sformatf("pulse_%0d", pidx), 32'(code), 32'(exp_q.pop_front()));
            end
            if (pidx == 16) t_conv = cyc;
            // conv wr at p, rdy back p+8, WAIT_CONV p+9..p+28, RST2 pulse p+29
            if (pidx == 17) chk("conv_gap", cyc - t_conv, CNT_CONV + 9);
            pidx++;
        end
        if (temp_vld | crc_err) begin
            n_res++;
            if (res_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_result: got vld=%0b err=%0b, expected none", temp_vld, crc_err);
            end else begin
                r = res_q.pop_front();
                chk("temp_vld", 32'(temp_vld), 32'(!r.err));
                chk("crc_err", 32'(crc_err), 32'(r.err));
                chk("temp", 32'(temp), 32'(r.t));
                chk("busy_at_done", 32'(busy), 32'd1);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i] ? P_W1 : P_W0);
    endtask

    task automatic push_meas();
        exp_q.push_back(P_RST);
        push_byte(8'hCC);
        push_byte(8'h44);
        exp_q.push_back(P_RST);
        push_byte(8'hCC);
        push_byte(8'hBE);
        for (int i = 0; i < RD_N; i++) exp_q.push_back(P_RD);
`ifndef DS_CRC_EN
        exp_q.push_back(P_RST);
`endif
    endtask

    task automatic set_data(input logic bad);
`ifdef DS_CRC_EN
        rd_bytes = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
        if (bad) rd_bytes[8] = 8'h1D;
`else
        rd_bytes = '{8'h91, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        if (bad) rd_bytes[8] = 8'hFF;
`endif
    endtask

    task automatic pulse_start(input int hold);
        @(posedge clk); #2;
        start = 1'b1;
        repeat (hold) @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic run_meas(input logic [15:0] exp_t, input logic exp_err, input int hold);
        int t;
        pidx = 0; rd_k = 0;
        push_meas();
        res_q.push_back({exp_err, exp_t});
        pulse_start(hold);
        t = 0;
        forever begin
            @(negedge clk);
            if (temp_vld || crc_err) break;
            t++;
            if (t > 4000) break;
        end
        if (t > 4000) begin
            n_tests++; n_fail++;
            $display("FAIL meas_timeout: got no temp_vld/crc_err, expected one within 4000 cycles");
        end else begin
            @(negedge clk);
            chk("busy_fall", 32'(busy), 32'd0);
            chk("pulse_queue_empty", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pulses"}, {29'd0, rst_en, wr_en, rd_en}, 32'd0);
        chk({tag, "_wdata"}, 32'(wdata), 32'd0);
        chk({tag, "_temp"}, 32'(temp), 32'd0);
        chk({tag, "_flags"}, {30'd0, temp_vld, crc_err}, 32'd0);
    endtask

`ifdef DS_CRC_EN
    localparam logic [15:0] T_GOOD = 16'h0550;
`else
    localparam logic [15:0] T_GOOD = 16'h0191;
`endif

    initial begin : stim
        int t, base;
        rst_n = 1'b1; start = 1'b0;
        set_data(1'b0);
        repeat (2) @(posedge clk);
        #2 start = 1'b1;                 // start while in reset must be ignored
        @(negedge clk);
        chk_reset_vals("init");
        @(posedge clk); #2;
        rst_n = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("idle_stays_idle", 32'(n_pulse), 32'd0);

        // full measurement with stray rdata_vld strobes outside RD
        inject = 1'b1;
        run_meas(T_GOOD, 1'b0, 1);
        inject = 1'b0;
`ifdef DS_CRC_EN
        set_data(1'b1);
        run_meas(16'h0550, 1'b1, 1);
        set_data(1'b0);
`endif

        // reset in the middle of RD
        pidx = 0; rd_k = 0;
        push_meas();
        pulse_start(1);
        t = 0;
        while (pidx < 40 && t < 4000) begin @(negedge clk); t++; end
        chk("reached_rd", 32'(pidx >= 40), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk_reset_vals("midrd");
        @(posedge clk); #2;
        rst_n = 1'b0;
        base = n_res;
        repeat (200) @(negedge clk);
        chk("no_vld_after_reset", 32'(n_res - base), 32'd0);

        // start held high for 10 cycles -> one measurement only
        run_meas(T_GOOD, 1'b0, 10);
        base = n_pulse;
        repeat (100) @(negedge clk);
        chk("no_queued_start", 32'(n_pulse - base), 32'd0);
        run_meas(T_GOOD, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
